mux_arb_pipe: RTL and testbench
===============================

# mux_arb_pipe

Parameterised N-channel arbitrated multiplexer with a registered output stage and valid/ready handshakes on every port. It generalises the plain select mux: the select is derived internally by fixed-priority or round-robin arbitration, and the result is held in a pipeline register. It sits where several requesters share one downstream consumer, such as instruction fetch and data access sharing one memory port, or multiple writeback sources.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- NCH, 4, number of input channels (≥1)
- MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin
- SEL_W, derived, $clog2(NCH), minimum 1

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discards the output register contents
- in_valid  in  NCH  per-channel request
- in_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_ready  out  NCH  one-hot or zero; channel k is accepted when in_valid[k] & in_ready[k]
- out_valid  out  1  output register holds data
- out_data  out  WIDTH  registered payload
- out_ch  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts when out_valid & out_ready

## Operation
- Reset values: out_valid=0, out_data=0, out_ch=0. The round-robin pointer is reset to last=NCH-1, so channel 0 has top priority.
- accept = !flush & (!out_valid | out_ready).
- Grant is combinational over in_valid:
  - MODE 0: lowest index with in_valid set.
  - MODE 1: first valid index searching upward from last+1, wrapping modulo NCH.
- in_ready[g] = accept & in_valid[g] for the granted g. All other in_ready bits are 0. in_ready never asserts for a channel whose in_valid is low.
- Transfer in: out_data←in_data[g], out_ch←g, out_valid←1. In MODE 1, last←g.
- Pointer updates only on transfer. A request that is stalled does not rotate the pointer.
- Output drained with no transfer in: out_valid←0. out_data and out_ch hold their previous values.
- Output stalled (out_valid & !out_ready): out_valid, out_data and out_ch are held exactly, and all in_ready are 0.
- Flush: next cycle out_valid=0. No input is accepted in the flush cycle, the pointer is unchanged, and out_data/out_ch hold. Flush overrides a simultaneous out_ready or in_valid.
- rst overrides flush and everything else, including mid-transfer.
- NCH=1: out_ch is always 0 and the arbitration degenerates to a pass-through register. MODE is irrelevant.
- in_data of non-granted channels is never sampled.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 transfer per cycle while out_ready stays high. Back-to-back works because drain and fill happen in the same cycle.
- in_ready depends combinationally on in_valid, out_valid, out_ready and flush. There is no combinational path from in_data to any output.
- Outputs are driven only by registers. out_valid/out_data/out_ch change only on clk edges.
- Fairness in MODE 1: with all NCH channels continuously valid and out_ready=1, every channel is granted exactly once per NCH consecutive transfers.

## Structure
- Shared package (e.g. cpu_pkg): ARB_FIXED=0, ARB_RR=1 mode constants, used both here and by the instantiating memory-port logic.
- Sub-module arb_rr:
  - Inputs: req[NCH], last[SEL_W], mode.
  - Outputs: grant one-hot, grant_idx[SEL_W], any.
  - Purely combinational; implemented as a double-width priority scan for the wrap.
- Top level holds the output register, the last pointer and the handshake logic.

## Test plan
- Reset then idle, all in_valid=0: out_valid=0, out_data=0, out_ch=0, in_ready=0000 on every cycle.
- MODE 0, NCH=4, in_valid=1010, data ch1=0x11, ch3=0x33, out_ready=1: ch1 is granted first (out_ch=1, out_data=0x11), then ch1 drops and ch3 follows on the next cycle. Channel 3 is never granted while ch1 is valid.
- MODE 1, in_valid=1111 held, out_ready=1: out_ch sequence after reset is 0,1,2,3,0,1,… with one transfer per cycle and no bubbles.
- Backpressure: out_valid=1 with out_data=0xAA and out_ready=0 for 3 cycles while ch2 is valid. in_ready stays 0000 and out_data stays 0xAA. On the cycle out_ready returns to 1, ch2 is accepted, and the next cycle shows out_ch=2. The pointer did not move during the stall.
- Flush while out_valid=1 and in_valid=0001, out_ready=1: next cycle out_valid=0, nothing is accepted in the flush cycle, and ch0 is accepted on the following cycle.
- rst asserted mid-stream in MODE 1 (last=2): next cycle out_valid=0. The next grant with in_valid=1111 is ch0.

Source files
------------

// File: rtl/mux_arb_pipe_pkg.sv
// rtl/mux_arb_pipe_pkg.sv - arbitration mode constants shared with the memory-port logic
package mux_arb_pipe_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Select width with a floor of one bit so single-channel builds still have a port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arb_pipe_arb_rr.sv
// rtl/mux_arb_pipe_arb_rr.sv - combinational fixed-priority / round-robin grant scan
module mux_arb_pipe_arb_rr
  import mux_arb_pipe_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int SEL_W = sel_width(NCH)
) (
  input  logic [NCH-1:0]   req_i,
  input  logic [SEL_W-1:0] last_i,
  input  logic             mode_i,
  output logic [NCH-1:0]   grant_o,
  output logic [SEL_W-1:0] grant_idx_o,
  output logic             any_o
);

  // Requests laid out twice so a scan starting mid-vector wraps without modulo logic.
  logic [2*NCH-1:0] req_dbl;
  assign req_dbl = {req_i, req_i};

  // Lowest set bit at or above the start position; start is last+1 in round-robin mode.
  always_comb begin
    int   start;
    logic found;
    start       = 0;
    found       = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    if (mode_i && (NCH > 1)) begin
      start = (int'(last_i) + 1) % NCH;
    end
    for (int j = 0; j < 2 * NCH; j++) begin
      if (!found && req_dbl[j] && (j >= start)) begin
        found              = 1'b1;
        grant_idx_o        = SEL_W'(j % NCH);
        grant_o[j % NCH]   = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mux_arb_pipe.sv
// rtl/mux_arb_pipe.sv - arbitrated N-channel mux with registered valid/ready output stage
module mux_arb_pipe
  import mux_arb_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = ARB_RR,
  parameter int SEL_W = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_ch,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] last_q,      last_d;

  logic [NCH-1:0]   grant;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_any;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  mux_arb_pipe_arb_rr #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i       (in_valid),
    .last_i      (last_q),
    .mode_i      (MODE == ARB_RR),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // The output slot can take a new word when empty or draining, unless flushed.
  assign accept   = !flush && (!out_valid_q || out_ready);
  assign xfer     = accept && grant_any;
  assign in_ready = accept ? grant : '0;

  // One-hot AND-OR select so only the granted channel's data reaches the register.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant[k]) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next state: fill on transfer, otherwise drop valid on drain or flush; stall holds.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
      if (MODE == ARB_RR) begin
        last_d = grant_idx;
      end
    end else if (flush || accept) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; the pointer resets to the top channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= SEL_W'(NCH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_pipe.sv
// tb/tb_mux_arb_pipe.sv - randomized and directed checks of mux_arb_pipe against a reference model
module tb_mux_arb_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         out_ready;
  logic [3:0]   in_valid;
  logic [127:0] in_data;

  logic [3:0]  rdy0, rdy1;
  logic        rdy2;
  logic        ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  oc0, oc1;
  logic        oc2;

  always #5 clk = ~clk;

  mux_arb_pipe #(.WIDTH(32), .NCH(4), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_ch(oc0), .out_ready(out_ready)
  );

  mux_arb_pipe #(.WIDTH(32), .NCH(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ch(oc1), .out_ready(out_ready)
  );

  mux_arb_pipe #(.WIDTH(32), .NCH(1), .MODE(1)) u_one (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[0]), .in_data(in_data[31:0]),
    .in_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_ch(oc2), .out_ready(out_ready)
  );

  int total = 0;
  int bad   = 0;

  int          nch  [3] = '{4, 4, 1};
  int          rr   [3] = '{0, 1, 1};
  int          m_val[3];
  int          m_ch [3];
  int          m_last[3];
  logic [31:0] m_dat[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next requester to serve: scan upward from just after the last winner (or from 0).
  function automatic int pick(input int n, input int is_rr, input int last, input logic [3:0] v);
    int s;
    s = is_rr != 0 ? (last + 1) % n : 0;
    for (int i = 0; i < n; i++) begin
      if (v[(s + i) % n]) return (s + i) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] dut_rdy(input int d);
    return d == 0 ? rdy0 : d == 1 ? rdy1 : {3'b000, rdy2};
  endfunction

  function automatic logic [33:0] dut_out(input int d);
    // {valid, ch(1 bit unused for d2), ...} packed as valid, ch[1:0]... returned separately below
    return d == 0 ? {ov0, 1'b0, od0} : d == 1 ? {ov1, 1'b0, od1} : {ov2, 1'b0, od2};
  endfunction

  function automatic logic [1:0] dut_ch(input int d);
    return d == 0 ? oc0 : d == 1 ? oc1 : {1'b0, oc2};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_val[d] = 0; m_ch[d] = 0; m_dat[d] = '0; m_last[d] = nch[d] - 1;
    end
  endtask

  // Check combinational ready, advance the model, then check registered outputs after the edge.
  task automatic cycle();
    logic [3:0]  v;
    logic [3:0]  er;
    logic [33:0] o;
    int          g;
    bit          acc;
    #1;
    for (int d = 0; d < 3; d++) begin
      v   = in_valid & (nch[d] == 4 ? 4'hF : 4'h1);
      acc = !flush && (m_val[d] == 0 || out_ready);
      g   = pick(nch[d], rr[d], m_last[d], v);
      er  = (acc && g >= 0) ? 4'(1 << g) : 4'h0;
      check($sformatf("in_ready[d%0d]", d), 64'(dut_rdy(d)), 64'(er));
      if (rst) begin
        m_val[d] = 0; m_ch[d] = 0; m_dat[d] = '0; m_last[d] = nch[d] - 1;
      end else if (acc && g >= 0) begin
        m_val[d] = 1; m_ch[d] = g; m_dat[d] = in_data[g*32 +: 32];
        if (rr[d] != 0) m_last[d] = g;
      end else if (flush || acc) begin
        m_val[d] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      o = dut_out(d);
      check($sformatf("out_valid[d%0d]", d), 64'(o[33]), 64'(m_val[d]));
      check($sformatf("out_data[d%0d]", d), 64'(o[31:0]), 64'(m_dat[d]));
      check($sformatf("out_ch[d%0d]", d), 64'(dut_ch(d)), 64'(m_ch[d]));
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic ordy, input logic [3:0] v);
    @(negedge clk);
    rst = r; flush = f; out_ready = ordy; in_valid = v;
    cycle();
  endtask

  task automatic rand_data();
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 4'h0; in_data = '0;
    model_reset();

    // Reset then idle
    drive(1, 0, 1, 4'h0);
    drive(1, 0, 1, 4'h0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 4'h0);

    // Fixed priority: ch1 before ch3
    in_data = {32'h33, 32'h0, 32'h11, 32'h0};
    drive(0, 0, 1, 4'b1010);
    check("fixed_first_ch", 64'(oc0), 64'd1);
    check("fixed_first_data", 64'(od0), 64'h11);
    drive(0, 0, 1, 4'b1000);
    check("fixed_second_ch", 64'(oc0), 64'd3);
    drive(0, 0, 1, 4'b0000);

    // Round-robin fairness after reset
    drive(1, 0, 1, 4'h0);
    for (int k = 0; k < 8; k++) begin
      rand_data();
      drive(0, 0, 1, 4'hF);
      check($sformatf("rr_seq%0d", k), 64'(oc1), 64'(k % 4));
      check($sformatf("rr_nobubble%0d", k), 64'(ov1), 64'd1);
    end

    // Backpressure with 0xAA held
    in_data = '0;
    in_data[31:0] = 32'hAA;
    in_data[95:64] = 32'hC2;
    drive(0, 0, 1, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 4'b0100);
      check("stall_hold_data", 64'(od0), 64'hAA);
    end
    drive(0, 0, 1, 4'b0100);
    check("stall_release_ch", 64'(oc0), 64'd2);
    check("stall_release_rr_ch", 64'(oc1), 64'd2);

    // Flush with out_valid high and ch0 requesting
    drive(0, 1, 1, 4'b0001);
    check("flush_valid", 64'(ov0), 64'd0);
    drive(0, 0, 1, 4'b0001);
    check("post_flush_ch", 64'(oc0), 64'd0);
    check("post_flush_valid", 64'(ov0), 64'd1);

    // Reset mid-stream with the round-robin pointer at 2
    drive(1, 0, 1, 4'h0);
    for (int k = 0; k < 3; k++) begin rand_data(); drive(0, 0, 1, 4'hF); end
    drive(1, 0, 1, 4'hF);
    check("rst_mid_valid", 64'(ov1), 64'd0);
    drive(0, 0, 1, 4'hF);
    check("rst_mid_grant", 64'(oc1), 64'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rand_data();
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
